// File: rtl/mgmt_spi_pkg.sv
// Shared definitions for the management SPI master: FSM states, opcodes
// understood by the management controller, and default timing.
// Optional build macro: MGMT_SPI_TURNAROUND_EN (adds a dummy byte after the opcode).
package mgmt_spi_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CS_SETUP,
      ST_SHIFT,
      ST_CS_HOLD,
      ST_CS_GAP
   } state_e;

   // SCK half-period in clk cycles (100 MHz / 8 = 12.5 MHz SCK)
   localparam int CLKDIV_DEFAULT    = 4;
   localparam int MAX_BYTES_DEFAULT = 8;

   // Opcodes shared with the management controller
   localparam logic [7:0] OP_WRITE_CTRL    = 8'h02;
   localparam logic [7:0] OP_READ_STATUS   = 8'h05;
   localparam logic [7:0] OP_READ_DIE_TEMP = 8'h30;
   localparam logic [7:0] OP_READ_SERIAL   = 8'h4B;
   localparam logic [7:0] OP_READ_IDCODE   = 8'h9F;

   // Bytes sent before the data phase: opcode, plus a dummy turnaround byte
`ifdef MGMT_SPI_TURNAROUND_EN
   localparam int HDR_BYTES = 2;
`else
   localparam int HDR_BYTES = 1;
`endif

   // Requested data byte count limited to what the data registers can hold
   function automatic logic [3:0] clamp_len(input logic [3:0] len, input int max_bytes);
      if (int'(len) > max_bytes) return 4'(max_bytes);
      return len;
   endfunction

endpackage

// File: rtl/spi_sck_gen.sv
// SCK generator: counts CLKDIV-cycle half periods while enabled, flags the
// end of each half period (tick) and, when toggling is enabled, produces the
// SCK level plus rise/fall strobes that are valid in the cycle before the
// clk edge on which SCK changes.
module spi_sck_gen
   import mgmt_spi_pkg::*;
#(
   parameter int CLKDIV = CLKDIV_DEFAULT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic run,
   input  logic toggle_en,
   output logic tick,
   output logic sck_rise,
   output logic sck_fall,
   output logic sck
);

   localparam logic [7:0] LAST = 8'(CLKDIV - 1);

   logic [7:0] cnt_q, cnt_d;
   logic       sck_q, sck_d;

   assign tick     = run && (cnt_q == LAST);
   assign sck_rise = tick && toggle_en && !sck_q;
   assign sck_fall = tick && toggle_en && sck_q;
   assign sck      = sck_q;

   // Next half-period count and SCK level; idle forces count and SCK to zero
   always_comb begin
      cnt_d = cnt_q;
      sck_d = sck_q;
      if (!run) begin
         cnt_d = '0;
         sck_d = 1'b0;
      end else if (tick) begin
         cnt_d = '0;
         if (toggle_en) sck_d = ~sck_q;
      end else begin
         cnt_d = cnt_q + 8'd1;
      end
   end

   // Half-period counter and SCK register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
         sck_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         sck_q <= sck_d;
      end
   end

endmodule

// File: rtl/mgmt_spi_master.sv
// Mode-0 SPI master for management transactions: one opcode byte followed by
// 0..MAX_BYTES data bytes under a single chip-select assertion. Write bytes go
// out MSB first while read bytes are captured into rd_data, right-aligned.
// Optional build macro: MGMT_SPI_TURNAROUND_EN inserts a 0x00 dummy byte
// between opcode and data phase whose MISO bits are discarded.
module mgmt_spi_master
   import mgmt_spi_pkg::*;
#(
   parameter int CLKDIV    = CLKDIV_DEFAULT,
   parameter int MAX_BYTES = MAX_BYTES_DEFAULT
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic [7:0]             opcode,
   input  logic [3:0]             len,
   input  logic [8*MAX_BYTES-1:0] wr_data,
   output logic                   busy,
   output logic                   done,
   output logic [8*MAX_BYTES-1:0] rd_data,
   output logic                   spi_sck,
   output logic                   spi_mosi,
   input  logic                   spi_miso,
   output logic                   spi_cs_n
);

   localparam int DW  = 8 * MAX_BYTES;
   localparam int HB  = 8 * HDR_BYTES;
   localparam int TW  = HB + DW;
   localparam int BCW = $clog2(TW + 1);

   state_e         state_q, state_d;
   logic [TW-1:0]  tx_q, tx_d;
   logic [DW-1:0]  rd_q, rd_d;
   logic [BCW-1:0] bit_cnt_q, bit_cnt_d;
   logic [BCW-1:0] nbits_q, nbits_d;
   logic           busy_q, busy_d;
   logic           done_q, done_d;
   logic           cs_n_q, cs_n_d;
   logic           mosi_q, mosi_d;

   logic           tick, sck_rise, sck_fall, sck;
   logic           gen_run, gen_toggle;

   logic [3:0]     len_c;
   logic [DW-1:0]  data_al;
   logic [TW-1:0]  tx_load;
   logic [BCW-1:0] nbits_load;
   int             align_sh;

   assign gen_run    = (state_q != ST_IDLE);
   assign gen_toggle = (state_q == ST_SHIFT);

   spi_sck_gen #(
      .CLKDIV (CLKDIV)
   ) u_sck_gen (
      .clk       (clk),
      .rst_n     (rst_n),
      .run       (gen_run),
      .toggle_en (gen_toggle),
      .tick      (tick),
      .sck_rise  (sck_rise),
      .sck_fall  (sck_fall),
      .sck       (sck)
   );

   // Build the transmit frame: opcode (and dummy byte), then the first len
   // data bytes moved to the top so the whole frame shifts out of the MSB
   always_comb begin
      len_c      = clamp_len(len, MAX_BYTES);
      align_sh   = 8 * (MAX_BYTES - int'(len_c));
      data_al    = wr_data << align_sh;
`ifdef MGMT_SPI_TURNAROUND_EN
      tx_load    = {opcode, 8'h00, data_al};
`else
      tx_load    = {opcode, data_al};
`endif
      nbits_load = BCW'(HB) + BCW'({len_c, 3'b000});
   end

   // Transaction sequencing: next state, shift registers and bus outputs
   always_comb begin
      state_d   = state_q;
      tx_d      = tx_q;
      rd_d      = rd_q;
      bit_cnt_d = bit_cnt_q;
      nbits_d   = nbits_q;
      busy_d    = busy_q;
      cs_n_d    = cs_n_q;
      mosi_d    = mosi_q;
      done_d    = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               tx_d      = tx_load;
               nbits_d   = nbits_load;
               bit_cnt_d = '0;
               rd_d      = '0;
               busy_d    = 1'b1;
               cs_n_d    = 1'b0;
               mosi_d    = opcode[7];
               state_d   = ST_CS_SETUP;
            end
         end
         ST_CS_SETUP: begin
            if (tick) state_d = ST_SHIFT;
         end
         ST_SHIFT: begin
            // Header bits (opcode, dummy) are clocked but not captured
            if (sck_rise && (bit_cnt_q >= BCW'(HB))) begin
               rd_d = {rd_q[DW-2:0], spi_miso};
            end
            if (sck_fall) begin
               tx_d   = tx_q << 1;
               mosi_d = tx_q[TW-2];
               if (bit_cnt_q == nbits_q - BCW'(1)) begin
                  state_d = ST_CS_HOLD;
               end else begin
                  bit_cnt_d = bit_cnt_q + BCW'(1);
               end
            end
         end
         ST_CS_HOLD: begin
            if (tick) begin
               cs_n_d  = 1'b1;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = ST_CS_GAP;
            end
         end
         ST_CS_GAP: begin
            if (tick) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and datapath registers; reset aborts any transfer immediately
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         tx_q      <= '0;
         rd_q      <= '0;
         bit_cnt_q <= '0;
         nbits_q   <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         cs_n_q    <= 1'b1;
         mosi_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         tx_q      <= tx_d;
         rd_q      <= rd_d;
         bit_cnt_q <= bit_cnt_d;
         nbits_q   <= nbits_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         cs_n_q    <= cs_n_d;
         mosi_q    <= mosi_d;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign rd_data  = rd_q;
   assign spi_sck  = sck;
   assign spi_mosi = mosi_q;
   assign spi_cs_n = cs_n_q;

endmodule

// File: tb/tb_mgmt_spi_master.sv
// Scoreboard bench for mgmt_spi_master: the driver computes each
// transaction's expected MOSI stream, read data, SCK edge count and latency
// from byte-level rules and queues it; an independent monitor rebuilds what
// it observes on the SPI pins and compares whenever done pulses.
module tb_mgmt_spi_master;

   localparam int CLKDIV = 4;
   localparam int MAXB   = 8;
`ifdef MGMT_SPI_TURNAROUND_EN
   localparam int HDR = 2;
`else
   localparam int HDR = 1;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [7:0]  opcode = '0;
   logic [3:0]  len = '0;
   logic [63:0] wr_data = '0;
   logic        busy, done, spi_sck, spi_mosi, spi_miso, spi_cs_n;
   logic [63:0] rd_data;

   mgmt_spi_master #(.CLKDIV(CLKDIV), .MAX_BYTES(MAXB)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .opcode   (opcode),
      .len      (len),
      .wr_data  (wr_data),
      .busy     (busy),
      .done     (done),
      .rd_data  (rd_data),
      .spi_sck  (spi_sck),
      .spi_mosi (spi_mosi),
      .spi_miso (spi_miso),
      .spi_cs_n (spi_cs_n)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [63:0] rd;
      int          lat;
      int          t_start;
      int          nbits;
      logic [79:0] stream;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        mon_e;
   int          n_chk = 0;
   int          n_fail = 0;

   // Slave model: loopback, or a preloaded bit string advanced on SCK falls
   logic        loop_mode = 1'b0;
   logic [79:0] slave_bits = '0;
   int          slave_idx = 0;

   always_comb begin
      spi_miso = 1'b0;
      if (loop_mode) spi_miso = spi_mosi;
      else if (slave_idx < 80) spi_miso = slave_bits[7'(79 - slave_idx)];
   end

   task automatic chk(input string name, input logic [79:0] act, input logic [79:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   // Monitor: rebuild the MOSI stream at SCK rises, check on every done
   int          mon_rises = 0;
   logic [79:0] mon_stream = '0;
   logic [63:0] last_rd = '0;
   logic        prev_sck = 1'b0;
   logic        prev_cs = 1'b1;

   always @(negedge clk) begin
      if (prev_cs && !spi_cs_n) begin
         mon_rises  = 0;
         mon_stream = '0;
      end
      if (spi_sck && !prev_sck) begin
         mon_rises++;
         mon_stream = {mon_stream[78:0], spi_mosi};
         chk("cs_low_at_sck_rise", 80'(spi_cs_n), 80'(0));
      end
      if (!spi_sck && prev_sck) slave_idx++;
      if (spi_cs_n) slave_idx = 0;
      if (done === 1'b1) begin
         n_chk++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_done: got done at cycle %0d, required no done", cyc);
         end else begin
            mon_e = exp_q.pop_front();
            chk("rd_data", 80'(rd_data), 80'(mon_e.rd));
            chk("latency", 80'(cyc - mon_e.t_start), 80'(mon_e.lat));
            chk("sck_rises", 80'(mon_rises), 80'(mon_e.nbits));
            chk("mosi_stream", mon_stream, mon_e.stream);
            chk("busy_low_at_done", 80'(busy), 80'(0));
            chk("cs_high_at_done", 80'(spi_cs_n), 80'(1));
            last_rd = mon_e.rd;
         end
      end
      prev_sck = spi_sck;
      prev_cs  = spi_cs_n;
   end

   // Reference model plus stimulus: frame = opcode, dummy, first len bytes
   task automatic issue(input logic [7:0] op, input logic [3:0] ln, input logic [63:0] wd,
                        input logic loop, input logic [63:0] resp);
      int          n;
      logic [7:0]  b[$];
      logic [7:0]  m;
      logic [79:0] sb;
      exp_t        e;
      n = (int'(ln) > MAXB) ? MAXB : int'(ln);
      b.push_back(op);
      if (HDR == 2) b.push_back(8'h00);
      for (int i = 0; i < n; i++) b.push_back(wd[8*(n-1-i) +: 8]);
      e.stream = '0;
      e.rd     = '0;
      sb       = '0;
      for (int k = 0; k < b.size(); k++) begin
         e.stream = (e.stream << 8) | 80'(b[k]);
         if (loop) m = b[k];
         else if (k < HDR) m = 8'hFF;
         else m = resp[8*(n-1-(k-HDR)) +: 8];
         if (k >= HDR) e.rd = (e.rd << 8) | 64'(m);
         sb[79-8*k -: 8] = m;
      end
      e.nbits = 8 * (HDR + n);
      e.lat   = 1 + CLKDIV + 2 * CLKDIV * e.nbits + CLKDIV;
      @(posedge clk); #1;
      loop_mode  = loop;
      slave_bits = sb;
      opcode     = op;
      len        = ln;
      wr_data    = wd;
      start      = 1'b1;
      e.t_start  = cyc;
      exp_q.push_back(e);
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input string name);
      logic seen;
      seen = 1'b0;
      for (int k = 0; k < 4000 && !seen; k++) begin
         @(negedge clk);
         if (done === 1'b1) seen = 1'b1;
      end
      n_chk++;
      if (!seen) begin
         n_fail++;
         $display("FAIL %s_timeout: got no done in 4000 cycles, required done", name);
      end
   endtask

   task automatic settle();
      repeat (CLKDIV + 3) @(posedge clk);
   endtask

   initial begin
      #800000;
      $display("FAIL watchdog: got no end of test by cycle %0d, required finish", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic seen5;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_busy", 80'(busy), 80'(0));
      chk("reset_done", 80'(done), 80'(0));
      chk("reset_rd_data", 80'(rd_data), 80'(0));
      chk("reset_sck", 80'(spi_sck), 80'(0));
      chk("reset_mosi", 80'(spi_mosi), 80'(0));
      chk("reset_cs_n", 80'(spi_cs_n), 80'(1));
      rst_n = 1'b1;
      repeat (2) @(posedge clk);

      // Opcode-only: slave drives 0xFF during opcode, rd_data must stay 0
      issue(8'h55, 4'd0, 64'h0, 1'b0, 64'h0);
      wait_done("t1"); settle();

      // Loopback write/read
      issue(8'h02, 4'd2, 64'hA5C3, 1'b1, 64'h0);
      wait_done("t2"); settle();

      // Slave returns fixed bytes
      issue(8'h04, 4'd4, 64'hDEAD_BEEF_0BAD_F00D, 1'b0, 64'h1234_5678);
      wait_done("t3"); settle();

      // Length clamp
      issue(8'h0B, 4'd12, 64'h0123_4567_89AB_CDEF, 1'b1, 64'h0);
      wait_done("t3_clamp"); settle();

      // Start while busy, then start in the first CS_GAP cycle
      issue(8'h30, 4'd3, 64'h0000_0000_00C0_FFEE, 1'b0, 64'h0000_0000_0077_8899);
      repeat (9) @(posedge clk);
      #1;
      chk("busy_mid_transfer", 80'(busy), 80'(1));
      start  = 1'b1;
      opcode = 8'hEE;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done("t4");
      start  = 1'b1;
      opcode = 8'h77;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (12) @(posedge clk);
      #1;
      chk("gap_start_cs_n", 80'(spi_cs_n), 80'(1));
      chk("gap_start_busy", 80'(busy), 80'(0));
      chk("rd_data_held", 80'(rd_data), 80'(last_rd));

      // Reset during bit 5 aborts with no done
      issue(8'h9F, 4'd4, 64'h1111_2222, 1'b0, 64'h3333_4444);
      seen5 = 1'b0;
      for (int k = 0; k < 500 && !seen5; k++) begin
         @(posedge clk);
         if (mon_rises >= 5) seen5 = 1'b1;
      end
      chk("reached_bit5", 80'(seen5), 80'(1));
      #1;
      rst_n = 1'b0;
      void'(exp_q.pop_back());
      @(posedge clk); #1;
      chk("abort_cs_n", 80'(spi_cs_n), 80'(1));
      chk("abort_sck", 80'(spi_sck), 80'(0));
      chk("abort_busy", 80'(busy), 80'(0));
      chk("abort_done", 80'(done), 80'(0));
      rst_n = 1'b1;
      repeat (30) @(posedge clk);
      issue(8'h05, 4'd1, 64'h5A, 1'b1, 64'h0);
      wait_done("t5_fresh"); settle();

`ifdef MGMT_SPI_TURNAROUND_EN
      // Turnaround byte in loopback
      issue(8'h01, 4'd1, 64'h3C, 1'b1, 64'h0);
      wait_done("t6"); settle();
`endif

      // Randomized transactions
      for (int t = 0; t < 12; t++) begin
         issue(8'($urandom), 4'($urandom_range(0, 15)), {$urandom, $urandom},
               1'($urandom_range(0, 1)), {$urandom, $urandom});
         wait_done("rand"); settle();
      end

      chk("scoreboard_empty", 80'(exp_q.size()), 80'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
